ntt_output_serializer: RTL and testbench

Downstream stage of the NTT processor. Captures the processor's parallel result burst (2 × CORE_COUNT 60-bit words per cycle while `output_active` is high) into a banked buffer, then streams the full transformed polynomial out in natural word order over a valid/ready interface with backpressure. It decouples the processor's fixed-rate output phase from slower consumers such as the host DMA or the next pipeline stage.

---
 rtl/ntt_pkg.sv | 36 +++
 rtl/ntt_out_bank.sv | 29 ++
 rtl/ntt_output_serializer.sv | 195 +++++++++++++++++++
 tb/tb_ntt_output_serializer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// Shared constants and types for the NTT output serializer.
// NTT_OUT_SPLIT_EN selects 30-bit half-word output beats.
`timescale 1ns/1ps
package ntt_pkg;

  localparam int LOG_N       = 12;
  localparam int COEFF_W     = 30;
  localparam int WORD_W      = 60;
  localparam int FRAME_LOG   = LOG_N - 1;
  localparam int FRAME_WORDS = 1 << FRAME_LOG;

`ifdef NTT_OUT_SPLIT_EN
  localparam int OUT_W = COEFF_W;
`else
  localparam int OUT_W = WORD_W;
`endif

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    DRAIN
  } ser_state_t;

  // Natural-order word index of bank (h,k) entry a.
  function automatic logic [FRAME_LOG-1:0] word_idx(
    input logic h,
    input int   k,
    input int   a,
    input int   depth_log
  );
    int w;
    w = (int'(h) << (FRAME_LOG - 1)) | (k << depth_log) | a;
    return w[FRAME_LOG-1:0];
  endfunction

endpackage

// File: rtl/ntt_out_bank.sv
// Simple dual-port RAM bank with a registered read port.
// Contents carry no reset and survive rst_n.
`timescale 1ns/1ps
module ntt_out_bank
  import ntt_pkg::*;
#(
  parameter int W  = WORD_W,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);

  logic [W-1:0] r_mem [1<<AW];
  logic [W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/ntt_output_serializer.sv
// Captures the NTT result burst into banked RAM and streams it out in natural order.
// Define NTT_OUT_SPLIT_EN to emit each 60-bit word as two 30-bit beats.
`timescale 1ns/1ps
module ntt_output_serializer
  import ntt_pkg::*;
#(
  parameter int LOG_CORE_COUNT = 4,
  parameter int DEPTH_LOG      = 10 - LOG_CORE_COUNT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              output_active,
  input  logic [WORD_W-1:0] in_data [1<<LOG_CORE_COUNT][2],
  input  logic [8:0]        in_address,
  output logic [OUT_W-1:0]  m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              busy,
  output logic              overrun,
  output logic              frame_err,
  input  logic              clear
);

  localparam int CC    = 1 << LOG_CORE_COUNT;
  localparam int NB    = 2 * CC;
  localparam int DEPTH = 1 << DEPTH_LOG;
  localparam int BW    = LOG_CORE_COUNT + 1;
  localparam logic [FRAME_LOG-1:0] LAST_W =
    word_idx(1'b1, CC - 1, DEPTH - 1, DEPTH_LOG);
  localparam logic [DEPTH_LOG:0] CAP_FULL =
    (DEPTH_LOG + 1)'(DEPTH);
  localparam logic [DEPTH_LOG:0] CAP_ONE =
    (DEPTH_LOG + 1)'(1);
  localparam logic [FRAME_LOG:0] RD_ONE =
    (FRAME_LOG + 1)'(1);

  ser_state_t r_state;
  ser_state_t w_state_nxt;

  logic [DEPTH_LOG:0]  r_cap_cnt;
  logic [FRAME_LOG:0]  r_rd_w;
  logic                r_rd_vld;
  logic                r_rd_last;
  logic [BW-1:0]       r_rd_bank;
  logic [WORD_W-1:0]   r_buf [2];
  logic [1:0]          r_buf_last;
  logic                r_wptr;
  logic                r_rptr;
  logic [1:0]          r_cnt;
  logic                r_overrun;
  logic                r_frame_err;

  logic [WORD_W-1:0]   w_bank_q [NB];
  logic [WORD_W-1:0]   w_rd_word;
  logic [WORD_W-1:0]   w_head;
  logic                w_head_last;
  logic                w_end_cap;
  logic                w_cap_we;
  logic                w_accept;
  logic                w_pop;
  logic                w_room;
  logic                w_issue;
  logic                w_unused;

  assign w_end_cap = (r_state == CAPTURE) && !output_active;
  assign w_cap_we  = output_active && (r_state != DRAIN);
  assign w_accept  = m_valid && m_ready;

  // Credit check: skid entries plus the read in flight never exceed two.
  assign w_room  = ({1'b0, r_cnt} + {2'b0, r_rd_vld})
                 < (3'd2 + {2'b0, w_pop});
  assign w_issue = w_room && (w_end_cap ||
                   (r_state == DRAIN && !r_rd_w[FRAME_LOG]));

  assign w_rd_word   = w_bank_q[r_rd_bank];
  assign w_head      = r_buf[r_rptr];
  assign w_head_last = r_buf_last[r_rptr];
  assign w_unused    = ^in_address[8:DEPTH_LOG];

  assign m_valid   = (r_cnt != 2'd0);
  assign busy      = (r_state != IDLE);
  assign overrun   = r_overrun;
  assign frame_err = r_frame_err;

`ifdef NTT_OUT_SPLIT_EN
  logic r_half;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_half <= 1'b0;
    else if (w_accept) r_half <= ~r_half;
  end

  assign w_pop  = w_accept && r_half;
  assign m_data = r_half ? w_head[WORD_W-1:COEFF_W]
                         : w_head[COEFF_W-1:0];
  assign m_last = m_valid && r_half && w_head_last;
`else
  assign w_pop  = w_accept;
  assign m_data = w_head;
  assign m_last = m_valid && w_head_last;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (output_active)    w_state_nxt = CAPTURE;
      CAPTURE: if (!output_active)   w_state_nxt = DRAIN;
      DRAIN:   if (w_accept && m_last) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cap_cnt   <= '0;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (r_state == IDLE)
        r_cap_cnt <= output_active ? CAP_ONE : '0;
      else if (r_state == CAPTURE && output_active &&
               r_cap_cnt != '1)
        r_cap_cnt <= r_cap_cnt + CAP_ONE;

      if (w_end_cap && r_cap_cnt != CAP_FULL)
        r_frame_err <= 1'b1;
      else if (clear)
        r_frame_err <= 1'b0;

      if (r_state == DRAIN && output_active)
        r_overrun <= 1'b1;
      else if (clear)
        r_overrun <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_w    <= '0;
      r_rd_vld  <= 1'b0;
      r_rd_last <= 1'b0;
      r_rd_bank <= '0;
    end else begin
      r_rd_vld <= w_issue;
      if (w_issue) begin
        r_rd_w    <= r_rd_w + RD_ONE;
        r_rd_bank <= r_rd_w[FRAME_LOG-1:DEPTH_LOG];
        r_rd_last <= (r_rd_w[FRAME_LOG-1:0] == LAST_W);
      end else if (r_state != DRAIN) begin
        r_rd_w <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf[0]   <= '0;
      r_buf[1]   <= '0;
      r_buf_last <= '0;
      r_wptr     <= 1'b0;
      r_rptr     <= 1'b0;
      r_cnt      <= '0;
    end else begin
      if (r_rd_vld) begin
        r_buf[r_wptr]      <= w_rd_word;
        r_buf_last[r_wptr] <= r_rd_last;
        r_wptr             <= ~r_wptr;
      end
      if (w_pop) r_rptr <= ~r_rptr;
      r_cnt <= r_cnt + {1'b0, r_rd_vld} - {1'b0, w_pop};
    end
  end

  for (genvar b = 0; b < NB; b++) begin : g_bank
    ntt_out_bank #(
      .W  (WORD_W),
      .AW (DEPTH_LOG)
    ) u_bank (
      .clk     (clk),
      .i_we    (w_cap_we),
      .i_waddr (in_address[DEPTH_LOG-1:0]),
      .i_wdata (in_data[b % CC][b / CC]),
      .i_re    (w_issue),
      .i_raddr (r_rd_w[DEPTH_LOG-1:0]),
      .o_rdata (w_bank_q[b])
    );
  end

endmodule

// File: tb/tb_ntt_output_serializer.sv
// Self-checking bench for ntt_output_serializer.
// Reference keeps a flat word-indexed image of the captured frame.
`timescale 1ns/1ps
module tb_ntt_output_serializer;
  import ntt_pkg::*;

  localparam int CC = 16;
  localparam int NW = 2048;
`ifdef NTT_OUT_SPLIT_EN
  localparam int BPW = 2;
`else
  localparam int BPW = 1;
`endif

  typedef struct {
    int len;
    int pct;
    int pulse;
    bit fe;
    bit ov;
  } row_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             output_active = 1'b0;
  logic             m_ready = 1'b0;
  logic             clear = 1'b0;
  logic [59:0]      in_data [CC][2];
  logic [8:0]       in_address = '0;
  logic [OUT_W-1:0] m_data;
  logic             m_valid, m_last, busy, overrun, frame_err;

  ntt_output_serializer #(.LOG_CORE_COUNT(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .output_active (output_active),
    .in_data       (in_data),
    .in_address    (in_address),
    .m_data        (m_data),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_last        (m_last),
    .busy          (busy),
    .overrun       (overrun),
    .frame_err     (frame_err),
    .clear         (clear)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rdy_pct = 100;
  int fall_cyc = 0;

  logic [59:0]      mem [NW];
  logic [59:0]      W0;
  logic [OUT_W-1:0] got [$];
  bit               lastq [$];
  int               first_valid_cyc = -1;
  int               last_acc_cyc = -1;
  int               stall_viol = 0;
  bit               last_busy = 0;
  bit               mon_en = 0;
  bit               prev_stall = 0;
  logic [OUT_W-1:0] prev_d;
  logic             prev_l;
  row_t             rows [6];

  always @(posedge clk) cyc = cyc + 1;

  always @(posedge clk) begin
    #1;
    m_ready = (rdy_pct >= 100) ||
              (int'($urandom_range(0, 99)) < rdy_pct);
  end

  always @(negedge clk) begin
    if (!rst_n || !mon_en) begin
      prev_stall = 0;
    end else begin
      if (prev_stall && !(m_valid && m_data == prev_d &&
                          m_last == prev_l))
        stall_viol++;
      if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (m_valid && m_ready) begin
        got.push_back(m_data);
        lastq.push_back(m_last);
        if (m_last) begin
          last_acc_cyc = cyc;
          last_busy = busy;
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_d = m_data;
      prev_l = m_last;
    end
  end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [OUT_W-1:0] exp_beat(input int i);
`ifdef NTT_OUT_SPLIT_EN
    logic [59:0] v;
    v = mem[i / 2];
    return (i % 2 == 1) ? v[59:30] : v[29:0];
`else
    return mem[i];
`endif
  endfunction

  task automatic capture(input int len, input bit force0);
    int off;
    int a;
    logic [63:0] r;
    off = $urandom_range(0, 63);
    got.delete();
    lastq.delete();
    first_valid_cyc = -1;
    last_acc_cyc = -1;
    stall_viol = 0;
    mon_en = 1;
    chk("busy_idle", 64'(busy), 64'd0);
    for (int i = 0; i < len; i++) begin
      a = (i + off) % 64;
      output_active = 1'b1;
      in_address = {3'($urandom_range(0, 7)), 6'(a)};
      for (int k = 0; k < CC; k++)
        for (int h = 0; h < 2; h++) begin
          r = {$urandom, $urandom};
          if (force0 && a == 0 && k == 0 && h == 0) r = {4'h0, W0};
          in_data[k][h] = r[59:0];
          mem[h * 1024 + k * 64 + a] = r[59:0];
        end
      @(posedge clk); #1;
      if (i == 0) chk("busy_rise", 64'(busy), 64'd1);
    end
    output_active = 1'b0;
    fall_cyc = cyc;
  endtask

  task automatic drain(input int pulse_beat, input int stop_beat);
    int t;
    bit pulsed;
    t = 0;
    pulsed = 0;
    while (last_acc_cyc < 0 && t < 20000) begin
      if (stop_beat >= 0 && got.size() >= stop_beat) return;
      if (!pulsed && pulse_beat >= 0 && got.size() >= pulse_beat) begin
        output_active = 1'b1;
        pulsed = 1;
      end else begin
        output_active = 1'b0;
      end
      @(posedge clk); #1;
      t++;
    end
    output_active = 1'b0;
    chk("drain_done", 64'(last_acc_cyc >= 0), 64'd1);
    chk("busy_fall", 64'(busy), 64'd0);
    chk("valid_after_last", 64'(m_valid), 64'd0);
    chk("busy_at_last", 64'(last_busy), 64'd1);
  endtask

  task automatic check_frame(input bit exp_fe, input bit exp_ov);
    int nmis;
    int nl;
    nmis = 0;
    nl = 0;
    chk("latency", 64'(first_valid_cyc - fall_cyc), 64'd2);
    chk("beat_count", 64'(got.size()), 64'(NW * BPW));
    for (int i = 0; i < got.size() && i < NW * BPW; i++)
      if (got[i] !== exp_beat(i)) nmis++;
    chk("beat_seq_mismatches", 64'(nmis), 64'd0);
    for (int i = 0; i < lastq.size(); i++) if (lastq[i]) nl++;
    chk("last_count", 64'(nl), 64'd1);
    if (lastq.size() > 0)
      chk("last_pos", 64'(lastq[lastq.size() - 1]), 64'd1);
    chk("hold_stable", 64'(stall_viol), 64'd0);
    chk("frame_err", 64'(frame_err), 64'(exp_fe));
    chk("overrun", 64'(overrun), 64'(exp_ov));
    mon_en = 0;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    chk("clear_frame_err", 64'(frame_err), 64'd0);
    chk("clear_overrun", 64'(overrun), 64'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_m_valid"}, 64'(m_valid), 64'd0);
    chk({tag, "_m_last"}, 64'(m_last), 64'd0);
    chk({tag, "_m_data"}, 64'(m_data), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_overrun"}, 64'(overrun), 64'd0);
    chk({tag, "_frame_err"}, 64'(frame_err), 64'd0);
  endtask

  initial begin
    W0 = 60'hABCDEF123456789;
    for (int k = 0; k < CC; k++)
      for (int h = 0; h < 2; h++) in_data[k][h] = '0;
    rows[0] = '{64, 100, -1, 1'b0, 1'b0};
    rows[1] = '{64, 50, -1, 1'b0, 1'b0};
    rows[2] = '{63, 100, -1, 1'b1, 1'b0};
    rows[3] = '{64, 100, 500, 1'b0, 1'b1};
    rows[4] = '{64, 100, -1, 1'b0, 1'b0};
    rows[5] = '{65, 70, -1, 1'b1, 1'b0};

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("por");
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      rdy_pct = rows[i].pct;
      capture(rows[i].len, 1'b0);
      drain(rows[i].pulse, -1);
      check_frame(rows[i].fe, rows[i].ov);
    end

    rdy_pct = 100;
    capture(64, 1'b0);
    drain(200, 1000);
    chk("pre_reset_overrun", 64'(overrun), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midrst");
    mon_en = 0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;

    capture(64, 1'b0);
    drain(-1, -1);
    check_frame(1'b0, 1'b0);

    rdy_pct = 60;
    capture(64, 1'b1);
    drain(-1, -1);
    check_frame(1'b0, 1'b0);
`ifdef NTT_OUT_SPLIT_EN
    chk("split_beat0", 64'(got[0]), {34'd0, W0[29:0]});
    chk("split_beat1", 64'(got[1]), {34'd0, W0[59:30]});
`else
    chk("word0", 64'(got[0]), {4'd0, W0});
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
